// File: rtl/dmem_arbiter.sv
// Two-port (CPU / HOST) arbiter and IDLE->ACCESS->RESP sequencer for the single-port data memory.
// Optional host lock chaining is enabled by defining DMEM_ARB_HOST_LOCK_EN.
//
// state  | meaning
// IDLE   | arbitrate; latch the winner's id, we, addr and wdata
// ACCESS | mem_en strobe with the latched access
// RESP   | winner's done pulse, read data capture, counter update, update last
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_cnt,
  output logic [CNT_W-1:0]  host_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant, pick_host;
  logic              sel_host, lat_we, last_host, lock_hold;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

`ifdef DMEM_ARB_HOST_LOCK_EN
  logic lock_q;

  // Armed by a locked host completion; only the IDLE cycle right after it can use it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                lock_q <= 1'b0;
    else if (state_q == RESP)  lock_q <= sel_host & host_lock;
    else if (state_q == IDLE)  lock_q <= 1'b0;
  end

  assign lock_hold = lock_q;
`else
  logic host_lock_unused;
  assign host_lock_unused = host_lock;
  assign lock_hold        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    pick_host = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          if (cpu_req && host_req) pick_host = lock_hold | ~last_host;
          else                     pick_host = host_req;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sel_host     <= 1'b0;
      lat_we       <= 1'b0;
      last_host    <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_done     <= 1'b0;
      host_done    <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_cnt      <= '0;
      host_cnt     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant) begin
            sel_host  <= pick_host;
            lat_we    <= pick_host ? host_we : cpu_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_host ? host_we : cpu_we;
            mem_addr  <= pick_host ? host_addr : cpu_addr;
            mem_wdata <= pick_host ? host_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          cpu_done  <= ~sel_host;
          host_done <= sel_host;
        end
        RESP: begin
          cpu_done  <= 1'b0;
          host_done <= 1'b0;
          last_host <= sel_host;
          if (sel_host) begin
            if (!lat_we)          host_rdata_q <= mem_rdata;
            if (host_cnt != '1)   host_cnt     <= host_cnt + CNT_W'(1);
          end else begin
            if (!lat_we)          cpu_rdata_q  <= mem_rdata;
            if (cpu_cnt != '1)    cpu_cnt      <= cpu_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The memory's registered read port delivers data in RESP, so read data is
  // forwarded during the done cycle and held in the capture register afterwards.
  assign cpu_rdata  = (cpu_done  && !lat_we) ? mem_rdata : cpu_rdata_q;
  assign host_rdata = (host_done && !lat_we) ? mem_rdata : host_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed traffic, expected memory strobes and
// port responses queued at issue time and checked by an independent monitor.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic        lock;
  } txn_t;

  typedef struct {
    logic        rd;
    logic [63:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [63:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_done, cpu_stall, host_done, mem_en, mem_we;
  logic [63:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic [15:0] cpu_cnt, host_cnt;

  logic        d4_cpu_done, d4_cpu_stall, d4_host_done, d4_mem_en, d4_mem_we;
  logic [63:0] d4_cpu_rdata, d4_host_rdata, d4_mem_addr, d4_mem_wdata;
  logic [3:0]  d4_cpu_cnt, d4_host_cnt;

  int n_checks = 0;
  int n_errors = 0;

  txn_t cpu_txq[$];
  txn_t host_txq[$];
  txn_t mem_q[$];
  rsp_t cpu_rsp_q[$];
  rsp_t host_rsp_q[$];
  bit [63:0] mem_arr [bit [63:0]];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_done(host_done), .host_rdata(host_rdata), .host_lock(host_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_cnt(cpu_cnt), .host_cnt(host_cnt)
  );

  dmem_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(d4_cpu_done), .cpu_rdata(d4_cpu_rdata), .cpu_stall(d4_cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_done(d4_host_done), .host_rdata(d4_host_rdata), .host_lock(host_lock),
    .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
    .mem_rdata(mem_rdata), .cpu_cnt(d4_cpu_cnt), .host_cnt(d4_host_cnt)
  );

  // Single-port memory with a registered read port.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_bad(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected or missing event at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a done.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_en) begin
        if (mem_q.size() == 0) report_bad("mem_en_extra");
        else begin
          txn_t e;
          e = mem_q.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {63'd0, mem_we}, {63'd0, e.we});
          chk("mem_wdata", mem_wdata, e.data);
        end
      end
      if (cpu_done) begin
        if (cpu_rsp_q.size() == 0) report_bad("cpu_done_extra");
        else begin
          rsp_t r;
          r = cpu_rsp_q.pop_front();
          if (r.rd) chk("cpu_rdata", cpu_rdata, r.data);
        end
      end
      if (host_done) begin
        if (host_rsp_q.size() == 0) report_bad("host_done_extra");
        else begin
          rsp_t r;
          r = host_rsp_q.pop_front();
          if (r.rd) chk("host_rdata", host_rdata, r.data);
        end
      end
    end
  end

  task automatic exp_mem(input logic [63:0] a, input logic w, input logic [63:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.data = d; t.lock = 1'b0;
    mem_q.push_back(t);
  endtask

  task automatic port_tx(input bit host, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic lk);
    txn_t t;
    rsp_t r;
    t.we = w; t.addr = a; t.data = w ? d : 64'd0; t.lock = lk;
    r.rd = ~w; r.data = d;
    if (host) begin host_txq.push_back(t); host_rsp_q.push_back(r); end
    else      begin cpu_txq.push_back(t);  cpu_rsp_q.push_back(r);  end
  endtask

  task automatic drive_cpu();
    txn_t t;
    int n;
    while (cpu_txq.size() != 0) begin
      t = cpu_txq.pop_front();
      cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.data;
      n = 0;
      do begin @(negedge clk); n++; end while (!cpu_done && n < 30);
      if (!cpu_done) begin report_bad("cpu_done_timeout"); cpu_txq.delete(); end
    end
    cpu_req = 1'b0;
  endtask

  task automatic drive_host();
    txn_t t;
    int n;
    while (host_txq.size() != 0) begin
      t = host_txq.pop_front();
      host_req = 1'b1; host_we = t.we; host_addr = t.addr; host_wdata = t.data;
      host_lock = t.lock;
      n = 0;
      do begin @(negedge clk); n++; end while (!host_done && n < 30);
      if (!host_done) begin report_bad("host_done_timeout"); host_txq.delete(); end
    end
    host_req = 1'b0;
    host_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
    mem_arr[64'h10] = 64'hDEAD;
    mem_arr[64'h20] = 64'h1111;
    mem_arr[64'h28] = 64'h2222;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_cpu_done", {63'd0, cpu_done}, 64'd0);
    chk("rst_cpu_cnt", {48'd0, cpu_cnt}, 64'd0);
    chk("rst_host_cnt", {48'd0, host_cnt}, 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single CPU read with cycle-exact timing
    exp_mem(64'h10, 1'b0, 64'd0);
    begin rsp_t r; r.rd = 1'b1; r.data = 64'hDEAD; cpu_rsp_q.push_back(r); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    after_edges(1);
    chk("t1_mem_en", {63'd0, mem_en}, 64'd1);
    chk("t1_stall_hi", {63'd0, cpu_stall}, 64'd1);
    after_edges(1);
    chk("t1_cpu_done", {63'd0, cpu_done}, 64'd1);
    chk("t1_cpu_rdata", cpu_rdata, 64'hDEAD);
    chk("t1_stall_lo", {63'd0, cpu_stall}, 64'd0);
    cpu_req = 1'b0;
    after_edges(1);
    chk("t1_cpu_cnt", {48'd0, cpu_cnt}, 64'd1);
    chk("t1_done_lo", {63'd0, cpu_done}, 64'd0);
    chk("t1_rdata_hold", cpu_rdata, 64'hDEAD);

    // Simultaneous requests after reset: CPU wins the first tie
    do_reset();
    exp_mem(64'h20, 1'b0, 64'd0);
    exp_mem(64'h28, 1'b0, 64'd0);
    begin rsp_t r; r.rd = 1'b1; r.data = 64'h1111; cpu_rsp_q.push_back(r);
          r.data = 64'h2222; host_rsp_q.push_back(r); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20;
    host_req = 1'b1; host_we = 1'b0; host_addr = 64'h28;
    after_edges(2);
    chk("t2_cpu_done", {63'd0, cpu_done}, 64'd1);
    chk("t2_host_wait", {63'd0, host_done}, 64'd0);
    cpu_req = 1'b0;
    after_edges(3);
    chk("t2_host_done", {63'd0, host_done}, 64'd1);
    host_req = 1'b0;
    @(negedge clk);

    // Four back-to-back writes per port, strict alternation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      port_tx(1'b0, 1'b1, 64'h100 + 64'(8 * i), 64'hC0 + 64'(i), 1'b0);
      port_tx(1'b1, 1'b1, 64'h200 + 64'(8 * i), 64'hA0 + 64'(i), 1'b0);
      exp_mem(64'h100 + 64'(8 * i), 1'b1, 64'hC0 + 64'(i));
      exp_mem(64'h200 + 64'(8 * i), 1'b1, 64'hA0 + 64'(i));
    end
    fork drive_cpu(); drive_host(); join
    after_edges(1);
    chk("t3_cpu_cnt", {48'd0, cpu_cnt}, 64'd4);
    chk("t3_host_cnt", {48'd0, host_cnt}, 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_mem_cpu", mem_arr[64'h100 + 64'(8 * i)], 64'hC0 + 64'(i));
      chk("t3_mem_host", mem_arr[64'h200 + 64'(8 * i)], 64'hA0 + 64'(i));
    end

    // Cross readback; last was HOST so the CPU wins the tie
    @(negedge clk);
    port_tx(1'b0, 1'b0, 64'h200, 64'hA0, 1'b0);
    port_tx(1'b0, 1'b0, 64'h218, 64'hA3, 1'b0);
    port_tx(1'b1, 1'b0, 64'h108, 64'hC1, 1'b0);
    exp_mem(64'h200, 1'b0, 64'd0);
    exp_mem(64'h108, 1'b0, 64'd0);
    exp_mem(64'h218, 1'b0, 64'd0);
    fork drive_cpu(); drive_host(); join
    after_edges(1);
    chk("t3b_cpu_cnt", {48'd0, cpu_cnt}, 64'd6);
    chk("t3b_host_cnt", {48'd0, host_cnt}, 64'd5);
    chk("t3b_cpu_hold", cpu_rdata, 64'hA3);
    chk("t3b_host_hold", host_rdata, 64'hC1);

    // Reset asserted during ACCESS
    @(negedge clk);
    exp_mem(64'h10, 1'b0, 64'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t4_mem_en_drop", {63'd0, mem_en}, 64'd0);
    chk("t4_cpu_cnt", {48'd0, cpu_cnt}, 64'd0);
    chk("t4_host_cnt", {48'd0, host_cnt}, 64'd0);
    chk("t4_cpu_rdata", cpu_rdata, 64'd0);
    chk("t4_host_rdata", host_rdata, 64'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t4_no_done", {63'd0, cpu_done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    port_tx(1'b0, 1'b0, 64'h208, 64'hA1, 1'b0);
    port_tx(1'b1, 1'b0, 64'h110, 64'hC2, 1'b0);
    exp_mem(64'h208, 1'b0, 64'd0);
    exp_mem(64'h110, 1'b0, 64'd0);
    fork drive_cpu(); drive_host(); join
    after_edges(1);
    chk("t4_cpu_cnt_after", {48'd0, cpu_cnt}, 64'd1);
    chk("t4_host_cnt_after", {48'd0, host_cnt}, 64'd1);

    // Host lock chain while the CPU is held
    do_reset();
    port_tx(1'b1, 1'b0, 64'h200, 64'hA0, 1'b1);
    port_tx(1'b1, 1'b0, 64'h208, 64'hA1, 1'b1);
    port_tx(1'b1, 1'b0, 64'h210, 64'hA2, 1'b1);
    port_tx(1'b0, 1'b0, 64'h100, 64'hC0, 1'b0);
`ifdef DMEM_ARB_HOST_LOCK_EN
    exp_mem(64'h200, 1'b0, 64'd0);
    exp_mem(64'h208, 1'b0, 64'd0);
    exp_mem(64'h210, 1'b0, 64'd0);
    exp_mem(64'h100, 1'b0, 64'd0);
`else
    port_tx(1'b0, 1'b0, 64'h108, 64'hC1, 1'b0);
    exp_mem(64'h200, 1'b0, 64'd0);
    exp_mem(64'h100, 1'b0, 64'd0);
    exp_mem(64'h208, 1'b0, 64'd0);
    exp_mem(64'h108, 1'b0, 64'd0);
    exp_mem(64'h210, 1'b0, 64'd0);
`endif
    fork
      drive_host();
      begin @(negedge clk); drive_cpu(); end
    join
    after_edges(1);
    chk("t5_host_cnt", {48'd0, host_cnt}, 64'd3);
`ifdef DMEM_ARB_HOST_LOCK_EN
    chk("t5_cpu_cnt", {48'd0, cpu_cnt}, 64'd1);
`else
    chk("t5_cpu_cnt", {48'd0, cpu_cnt}, 64'd2);
`endif

    // Counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      port_tx(1'b0, 1'b1, 64'h300 + 64'(8 * i), 64'h5000 + 64'(i), 1'b0);
      exp_mem(64'h300 + 64'(8 * i), 1'b1, 64'h5000 + 64'(i));
    end
    drive_cpu();
    after_edges(1);
    chk("t6_cpu_cnt16", {48'd0, cpu_cnt}, 64'd17);
    chk("t6_cpu_cnt4_sat", {60'd0, d4_cpu_cnt}, 64'd15);
    chk("t6_host_cnt4", {60'd0, d4_host_cnt}, 64'd0);

    @(negedge clk);
    chk("end_mem_q_empty", 64'(mem_q.size()), 64'd0);
    chk("end_cpu_q_empty", 64'(cpu_rsp_q.size()), 64'd0);
    chk("end_host_q_empty", 64'(host_rsp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
